xc_malu_mul_seq: RTL and testbench
==================================

XC_MALU_MUL_SEQ -- requirements
Module: xc_malu_mul_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock input 1 is the rising-edge clock; reset input 1 is the synchronous active-high reset.
REQ-002 SHALL have ports, one per line as name / direction / width / meaning:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- valid  in  1  operation request; held high until ready or flush
- flush  in  1  abort any operation
- op  in  3  0 mul, 1 mulh, 2 mulhu, 3 mulhsu, 4 clmul, 5 clmulh, 6-7 reserved
- rs1  in  32  multiplicand
- rs2  in  32  multiplier
- ready  out  1  result valid, single-cycle pulse
- busy  out  1  operation in progress
- result  out  32  product word; zero when ready is low
- mul_rs1  out  32  registered rs1 to step unit
- mul_rs2  out  32  registered rs2 to step unit
- mul_count  out  6  step counter
- mul_acc  out  64  accumulator
- mul_arg_0  out  32  shifting multiplier
- mul_carryless  out  1  carry-less mode
- mul_lhs_sign  out  1  rs1 signed
- mul_rhs_sign  out  1  rs2 signed
- mul_n_acc  in  64  next accumulator from step unit
- mul_n_arg_0  in  32  next multiplier from step unit
- mul_ready  in  1  step unit finished (count==32 for 32-bit packing)

Function
REQ-003 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-004 In IDLE, when valid=1, flush=0 and op<=5, the block SHALL latch rs1 and rs2 into mul_rs1 and mul_rs2, load arg_0<=rs2, acc<=0 and count<=0, latch op, and go to RUN.
REQ-005 In IDLE, when valid=1, flush=0 and op>=6, the block SHALL go directly to DONE with acc=0.
REQ-006 In RUN with mul_ready=0, the block SHALL update acc<=mul_n_acc and arg_0<=mul_n_arg_0, and set count<=count+1.
REQ-007 In RUN with mul_ready=1, the block SHALL leave acc and arg_0 unchanged and go to DONE.
REQ-008 In DONE, the block SHALL assert ready for one cycle and go to IDLE unconditionally; a new operation SHALL start only from IDLE.
REQ-009 Latency for a legal op accepted in cycle T: RUN SHALL occupy cycles T+1..T+33 (32 updates plus 1 completion cycle), and ready SHALL be high in T+34.
REQ-010 Latency for a reserved op accepted in cycle T: ready SHALL be high in T+1.
REQ-011 The sign and carry-less controls SHALL be decoded from the latched op:
- mul_lhs_sign = 1 for op 1 and 3;
- mul_rhs_sign = 1 for op 1 only;
- mul_carryless = 1 for op 4 and 5;
- all three SHALL be 0 otherwise.
REQ-012 result SHALL be acc[31:0] for op 0 and 4, acc[63:32] for op 1, 2, 3 and 5, and 0 for reserved ops; result SHALL be 0 whenever ready=0.
REQ-013 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-014 mul_rs1, mul_rs2 and the latched op SHALL stay constant from the accept cycle until the block returns to IDLE; changes on rs1, rs2 or op while busy SHALL be ignored.
REQ-015 flush=1 in any state SHALL force IDLE on the next edge, with ready=0 in that cycle, and count, acc and arg_0 cleared.
REQ-016 flush has priority over valid: a simultaneous valid and flush in IDLE SHALL NOT start an operation.
REQ-017 count SHALL never exceed 32; it SHALL NOT wrap, because mul_ready terminates RUN.
REQ-018 A mul_ready assertion while in IDLE or DONE SHALL be ignored.

Reset
REQ-019 While reset=1, the block SHALL enter IDLE at the clock edge, including when reset arrives mid-operation.
REQ-020 While reset=1, the block SHALL drive ready=0, busy=0 and result=0.
REQ-021 While reset=1, the block SHALL clear mul_count, mul_acc, mul_arg_0, mul_rs1 and mul_rs2 to 0, and mul_carryless, mul_lhs_sign and mul_rhs_sign to 0.
REQ-022 Reset SHALL have priority over flush and valid.

Verification
REQ-023 mul test: op=0, rs1=3, rs2=5, accepted in T -> ready at T+34, result=0x0000000F, busy low at T+35.
REQ-024 Signed/unsigned test: op=1 with rs1=rs2=0xFFFFFFFF -> result=0x00000000; op=2 with the same operands -> result=0xFFFFFFFE; op=3 with the same operands -> result=0xFFFFFFFF.
REQ-025 Carry-less test: op=4 with rs1=rs2=3 -> result=0x00000005; op=5 with rs1=rs2=0x80000000 -> result=0x40000000.
REQ-026 Flush test: pulse flush when mul_count=10 -> IDLE next cycle and no ready pulse; a following mul 7*6 -> result=0x0000002A.
REQ-027 Reserved-op test: op=7 accepted in T -> ready at T+1 with result=0; ready=0 at T+2.
REQ-028 Reset test: assert reset while mul_count=20 -> next cycle busy=0 and all registers zero; changing rs1 or rs2 mid-RUN (after a fresh start) -> result unaffected.

Source files
------------

// File: rtl/xc_malu_mul_seq_if.sv
// rtl/xc_malu_mul_seq_if.sv - request/response bundle for the sequential multiplier
interface xc_malu_mul_seq_if;
    logic        valid;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        ready;
    logic        busy;
    logic [31:0] result;

    modport master (
        output valid, flush, op, rs1, rs2,
        input  ready, busy, result
    );

    modport slave (
        input  valid, flush, op, rs1, rs2,
        output ready, busy, result
    );
endinterface

// File: rtl/xc_malu_mul_seq.sv
// rtl/xc_malu_mul_seq.sv - sequencer driving an external 32-step multiply/carry-less step unit
module xc_malu_mul_seq (
    input  logic                 clock,
    input  logic                 reset,
    xc_malu_mul_seq_if.slave     bus,
    output logic [31:0]          mul_rs1,
    output logic [31:0]          mul_rs2,
    output logic [5:0]           mul_count,
    output logic [63:0]          mul_acc,
    output logic [31:0]          mul_arg_0,
    output logic                 mul_carryless,
    output logic                 mul_lhs_sign,
    output logic                 mul_rhs_sign,
    input  logic [63:0]          mul_n_acc,
    input  logic [31:0]          mul_n_arg_0,
    input  logic                 mul_ready
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [5:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] arg_q, arg_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            rs1_q   <= 32'd0;
            rs2_q   <= 32'd0;
            count_q <= 6'd0;
            acc_q   <= 64'd0;
            arg_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            arg_q   <= arg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        count_d = count_q;
        acc_d   = acc_q;
        arg_d   = arg_q;
        case (state_q)
            S_IDLE: begin
                if (bus.valid && !bus.flush) begin
                    op_d  = bus.op;
                    acc_d = 64'd0;
                    if (bus.op <= 3'd5) begin
                        rs1_d   = bus.rs1;
                        rs2_d   = bus.rs2;
                        arg_d   = bus.rs2;
                        count_d = 6'd0;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (mul_ready) begin
                    state_d = S_DONE;
                end else begin
                    acc_d = mul_n_acc;
                    arg_d = mul_n_arg_0;
                    // Saturate so a missing mul_ready can never wrap the step index.
                    if (count_q != 6'd32) begin
                        count_d = count_q + 6'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
            count_d = 6'd0;
            acc_d   = 64'd0;
            arg_d   = 32'd0;
        end
    end

    always_comb begin
        bus.ready  = (state_q == S_DONE) && !bus.flush && !reset;
        bus.busy   = (state_q != S_IDLE) && !reset;
        bus.result = 32'd0;
        if (bus.ready) begin
            case (op_q)
                3'd0, 3'd4:             bus.result = acc_q[31:0];
                3'd1, 3'd2, 3'd3, 3'd5: bus.result = acc_q[63:32];
                default:                bus.result = 32'd0;
            endcase
        end
    end

    assign mul_rs1       = rs1_q;
    assign mul_rs2       = rs2_q;
    assign mul_count     = count_q;
    assign mul_acc       = acc_q;
    assign mul_arg_0     = arg_q;
    assign mul_lhs_sign  = (op_q == 3'd1) || (op_q == 3'd3);
    assign mul_rhs_sign  = (op_q == 3'd1);
    assign mul_carryless = (op_q == 3'd4) || (op_q == 3'd5);
endmodule

// File: tb/tb_xc_malu_mul_seq.sv
// tb/tb_xc_malu_mul_seq.sv - directed scoreboard bench for xc_malu_mul_seq with a behavioural step unit
module tb_xc_malu_mul_seq;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mul_rs1, mul_rs2, mul_arg_0, mul_n_arg_0;
    logic [5:0]  mul_count;
    logic [63:0] mul_acc, mul_n_acc;
    logic        mul_carryless, mul_lhs_sign, mul_rhs_sign, mul_ready;
    logic        force_rdy;
    logic [63:0] lhs_ext, term;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    xc_malu_mul_seq_if bus ();

    xc_malu_mul_seq dut (
        .clock(clock), .reset(reset), .bus(bus),
        .mul_rs1(mul_rs1), .mul_rs2(mul_rs2), .mul_count(mul_count),
        .mul_acc(mul_acc), .mul_arg_0(mul_arg_0), .mul_carryless(mul_carryless),
        .mul_lhs_sign(mul_lhs_sign), .mul_rhs_sign(mul_rhs_sign),
        .mul_n_acc(mul_n_acc), .mul_n_arg_0(mul_n_arg_0), .mul_ready(mul_ready)
    );

    always #5 clock = ~clock;

    // Step unit: one partial product per count, MSB of a signed multiplier has negative weight.
    always_comb begin
        lhs_ext     = mul_lhs_sign ? {{32{mul_rs1[31]}}, mul_rs1} : {32'd0, mul_rs1};
        term        = mul_arg_0[0] ? (lhs_ext << mul_count[4:0]) : 64'd0;
        mul_n_arg_0 = mul_arg_0 >> 1;
        if (mul_carryless)                              mul_n_acc = mul_acc ^ term;
        else if (mul_rhs_sign && mul_count == 6'd31)    mul_n_acc = mul_acc - term;
        else                                            mul_n_acc = mul_acc + term;
        mul_ready = (mul_count == 6'd32) || force_rdy;
    end

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 3'd1 || op == 3'd3) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        if (op == 3'd4 || op == 3'd5) begin
            p = 64'd0;
            for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'd0, a} << i);
        end
        case (op)
            3'd0, 3'd4:             return p[31:0];
            3'd1, 3'd2, 3'd3, 3'd5: return p[63:32];
            default:                return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input bit scramble);
        int lat;
        bit seen;
        logic [31:0] want;
        @(negedge clock);
        bus.valid = 1'b1; bus.op = op; bus.rs1 = a; bus.rs2 = b;
        exp_q.push_back(exp);
        @(negedge clock);
        bus.valid = 1'b0;
        check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
        if (scramble) begin
            bus.rs1 = ~a; bus.rs2 = $urandom; bus.op = ~op;
        end
        lat = 1; seen = 1'b0;
        while (!seen && lat < 80) begin
            if (bus.ready) seen = 1'b1;
            else begin @(negedge clock); lat++; end
        end
        check("ready_seen", {63'd0, seen}, 64'd1);
        check("latency", 64'(lat), 64'(exp_lat));
        want = exp_q.pop_front();
        check("result", {32'd0, bus.result}, {32'd0, want});
        if (scramble) begin
            check("rs1_held", {32'd0, mul_rs1}, {32'd0, a});
            check("rs2_held", {32'd0, mul_rs2}, {32'd0, b});
        end
        @(negedge clock);
        check("ready_cleared", {63'd0, bus.ready}, 64'd0);
        check("busy_cleared", {63'd0, bus.busy}, 64'd0);
        check("result_idle", {32'd0, bus.result}, 64'd0);
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, "_busy"},   {63'd0, bus.busy}, 64'd0);
        check({tag, "_ready"},  {63'd0, bus.ready}, 64'd0);
        check({tag, "_result"}, {32'd0, bus.result}, 64'd0);
        check({tag, "_count"},  {58'd0, mul_count}, 64'd0);
        check({tag, "_acc"},    mul_acc, 64'd0);
        check({tag, "_arg0"},   {32'd0, mul_arg_0}, 64'd0);
        check({tag, "_rs1"},    {32'd0, mul_rs1}, 64'd0);
        check({tag, "_rs2"},    {32'd0, mul_rs2}, 64'd0);
        check({tag, "_ctl"},    {61'd0, mul_carryless, mul_lhs_sign, mul_rhs_sign}, 64'd0);
    endtask

    initial begin
        int n;
        int pulses;
        logic [31:0] a, b;
        logic [2:0] op;
        reset = 1'b1; force_rdy = 1'b0;
        bus.valid = 1'b0; bus.flush = 1'b0; bus.op = 3'd0; bus.rs1 = 32'd0; bus.rs2 = 32'd0;
        repeat (2) @(negedge clock);
        check_regs_zero("reset_state");
        reset = 1'b0;

        run_op(3'd0, 32'd3, 32'd5, 32'h0000000F, 34, 1'b0);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, 1'b0);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1'b0);
        run_op(3'd4, 32'd3, 32'd3, 32'h00000005, 34, 1'b0);
        run_op(3'd5, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0);

        // Flush mid-run: no ready pulse may follow.
        @(negedge clock);
        bus.valid = 1'b1; bus.op = 3'd0; bus.rs1 = 32'd9; bus.rs2 = 32'd9;
        @(negedge clock);
        bus.valid = 1'b0;
        n = 0;
        while (mul_count != 6'd10 && n < 50) begin @(negedge clock); n++; end
        check("flush_reach_count10", {58'd0, mul_count}, 64'd10);
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        check("flush_busy", {63'd0, bus.busy}, 64'd0);
        check("flush_count", {58'd0, mul_count}, 64'd0);
        check("flush_acc", mul_acc, 64'd0);
        check("flush_arg0", {32'd0, mul_arg_0}, 64'd0);
        pulses = 0;
        repeat (40) begin @(negedge clock); if (bus.ready) pulses++; end
        check("flush_no_ready", 64'(pulses), 64'd0);
        run_op(3'd0, 32'd7, 32'd6, 32'h0000002A, 34, 1'b0);

        run_op(3'd7, 32'h1234, 32'h5678, 32'd0, 1, 1'b0);
        run_op(3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1, 1'b0);

        // Simultaneous valid and flush in IDLE must not start anything.
        @(negedge clock);
        bus.valid = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.rs1 = 32'hDEAD; bus.rs2 = 32'hBEEF;
        @(negedge clock);
        bus.valid = 1'b0; bus.flush = 1'b0;
        check("valid_flush_busy", {63'd0, bus.busy}, 64'd0);
        check("valid_flush_rs1", {32'd0, mul_rs1}, 64'd7);

        force_rdy = 1'b1;
        @(negedge clock);
        force_rdy = 1'b0;
        check("idle_mul_ready_busy", {63'd0, bus.busy}, 64'd0);
        check("idle_mul_ready_ready", {63'd0, bus.ready}, 64'd0);

        // Reset mid-run with signed controls active.
        @(negedge clock);
        bus.valid = 1'b1; bus.op = 3'd3; bus.rs1 = 32'hAAAA5555; bus.rs2 = 32'h0F0F0F0F;
        @(negedge clock);
        bus.valid = 1'b0;
        n = 0;
        while (mul_count != 6'd20 && n < 50) begin @(negedge clock); n++; end
        check("reset_reach_count20", {58'd0, mul_count}, 64'd20);
        check("mulhsu_ctl", {61'd0, mul_carryless, mul_lhs_sign, mul_rhs_sign}, 64'd2);
        reset = 1'b1;
        @(negedge clock);
        check_regs_zero("midrun_reset");
        reset = 1'b0;

        run_op(3'd0, 32'h12345678, 32'h9ABCDEF0, ref_result(3'd0, 32'h12345678, 32'h9ABCDEF0), 34, 1'b1);
        run_op(3'd1, 32'h80000000, 32'h7FFFFFFF, ref_result(3'd1, 32'h80000000, 32'h7FFFFFFF), 34, 1'b1);

        for (int i = 0; i < 4; i++) begin
            a  = $urandom; b = $urandom;
            op = 3'($urandom_range(0, 5));
            run_op(op, a, b, ref_result(op, a, b), 34, 1'b0);
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
